// File: rtl/pc_sequencer_if.sv
// Control-flow bundle between the CPU control FSM and the PC sequencer.
// The master drives the step and instruction-class inputs; the slave returns the PC and status.
interface pc_sequencer_if #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
);
  logic                     step;
  logic                     branch;
  logic                     jump;
  logic                     call;
  logic                     ret;
  logic                     halt;
  logic [PC_W-1:0]          target;
  logic [PC_W-1:0]          pc;
  logic                     taken;
  logic [$clog2(DEPTH):0]   sp;
  logic                     halted;
  logic                     fault;

  modport master (
    output step, branch, jump, call, ret, halt, target,
    input  pc, taken, sp, halted, fault
  );

  modport slave (
    input  step, branch, jump, call, ret, halt, target,
    output pc, taken, sp, halted, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: sequential/branch/call/return update per step, with a return-address stack.
// One-cycle registered latency; HALT and FAULT are sticky until synchronous reset.
module pc_sequencer #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc;
  logic [SP_W-1:0] sp_q, sp_nxt;
  logic            taken_q, taken_nxt;
  logic            push;
  logic [AW-1:0]   push_idx, pop_idx;
  logic            stack_full, stack_empty;
  logic [PC_W-1:0] stack [DEPTH];

  assign pc_inc      = pc_q + PC_W'(1);
  assign push_idx    = sp_q[AW-1:0];
  assign pop_idx     = AW'(sp_q - SP_W'(1));
  assign stack_full  = (sp_q == SP_W'(DEPTH));
  assign stack_empty = (sp_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      sp_q    <= sp_nxt;
      taken_q <= taken_nxt;
    end
  end

  // Stack entries need no reset: sp bounds every read to previously written slots.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    sp_nxt    = sp_q;
    taken_nxt = 1'b0;
    push      = 1'b0;
    if (state == S_RUN && bus.step) begin
      if (bus.halt) begin
        state_nxt = S_HALT;
      end else if (bus.ret) begin
        if (stack_empty) begin
          state_nxt = S_FAULT;
        end else begin
          pc_nxt    = stack[pop_idx];
          sp_nxt    = sp_q - SP_W'(1);
          taken_nxt = 1'b1;
        end
      end else if (bus.call) begin
        if (stack_full) begin
          state_nxt = S_FAULT;
        end else begin
          push      = 1'b1;
          pc_nxt    = bus.target;
          sp_nxt    = sp_q + SP_W'(1);
          taken_nxt = 1'b1;
        end
      end else if (bus.branch && bus.jump) begin
        pc_nxt    = bus.target;
        taken_nxt = 1'b1;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  assign bus.pc     = pc_q;
  assign bus.taken  = taken_q;
  assign bus.sp     = sp_q;
  assign bus.halted = (state == S_HALT);
  assign bus.fault  = (state == S_FAULT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stk [$];
  bit              m_halted, m_fault, m_taken;

  pc_sequencer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},     32'(bus.pc),     32'(m_pc));
    chk({tag, "_taken"},  32'(bus.taken),  32'(m_taken));
    chk({tag, "_sp"},     32'(bus.sp),     32'(m_stk.size()));
    chk({tag, "_halted"}, 32'(bus.halted), 32'(m_halted));
    chk({tag, "_fault"},  32'(bus.fault),  32'(m_fault));
  endtask

  // Reference model: the return stack is a queue, the status flags plain booleans.
  task automatic model(input bit r, s, b, j, c, rt, h, input logic [PC_W-1:0] t);
    m_taken = 1'b0;
    if (!r) begin
      m_pc = '0;
      m_stk.delete();
      m_halted = 1'b0;
      m_fault  = 1'b0;
    end else if (m_halted || m_fault || !s) begin
      // nothing moves
    end else if (h) begin
      m_halted = 1'b1;
    end else if (rt) begin
      if (m_stk.size() == 0) m_fault = 1'b1;
      else begin
        m_pc    = m_stk.pop_back();
        m_taken = 1'b1;
      end
    end else if (c) begin
      if (m_stk.size() == DEPTH) m_fault = 1'b1;
      else begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc    = t;
        m_taken = 1'b1;
      end
    end else if (b && j) begin
      m_pc    = t;
      m_taken = 1'b1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic cyc(input string tag, input bit r, s, b, j, c, rt, h, input logic [PC_W-1:0] t);
    rst_n      = r;
    bus.step   = s;
    bus.branch = b;
    bus.jump   = j;
    bus.call   = c;
    bus.ret    = rt;
    bus.halt   = h;
    bus.target = t;
    model(r, s, b, j, c, rt, h, t);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit s, b, j, c, rt, h, r;
    logic [PC_W-1:0] t;
    rst_n = 1'b0;
    bus.step = 0; bus.branch = 0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.halt = 0; bus.target = '0;
    #2;

    // 1: reset, then three plain steps
    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 16'h0);
    chk("rst_pc_const", 32'(bus.pc), 0);
    for (int i = 1; i <= 3; i++) cyc("seq", 1, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("seq_pc3_const", 32'(bus.pc), 3);

    // 2: not-taken then taken branch from pc=5
    cyc("rst2", 0, 0, 0, 0, 0, 0, 0, 16'h0);
    cyc("to5", 1, 1, 1, 1, 0, 0, 0, 16'h0005);
    cyc("br_nt", 1, 1, 1, 0, 0, 0, 0, 16'h0040);
    chk("br_nt_pc_const", 32'(bus.pc), 6);
    cyc("br_t", 1, 1, 1, 1, 0, 0, 0, 16'h0040);
    chk("br_t_pc_const", 32'(bus.pc), 32'h40);
    cyc("br_after", 1, 1, 0, 0, 0, 0, 0, 16'h0);

    // 3: call / return round trip
    cyc("to10", 1, 1, 1, 1, 0, 0, 0, 16'h0010);
    cyc("call", 1, 1, 0, 0, 1, 0, 0, 16'h0100);
    cyc("sub1", 1, 1, 0, 0, 0, 0, 0, 16'h0);
    cyc("sub2", 1, 1, 0, 0, 0, 0, 0, 16'h0);
    cyc("ret", 1, 1, 0, 0, 0, 1, 0, 16'h0);
    chk("ret_pc_const", 32'(bus.pc), 32'h11);

    // 4: fill the stack, overflow, then reset
    cyc("rst4", 0, 1, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 5; i++) cyc("calln", 1, 1, 0, 0, 1, 0, 0, 16'(i * 256));
    chk("ovf_fault_const", 32'(bus.fault), 1);
    chk("ovf_pc_const", 32'(bus.pc), 32'h400);
    cyc("ovf_ign", 1, 1, 1, 1, 0, 0, 0, 16'h1234);
    cyc("ovf_ign2", 1, 1, 0, 0, 0, 1, 0, 16'h0);
    cyc("rst4b", 0, 0, 0, 0, 0, 0, 0, 16'h0);

    // 5: underflow; halt outranks call and branch
    cyc("unf", 1, 1, 0, 0, 0, 1, 0, 16'h0);
    chk("unf_fault_const", 32'(bus.fault), 1);
    cyc("rst5", 0, 0, 0, 0, 0, 0, 0, 16'h0);
    cyc("c20", 1, 1, 0, 0, 1, 0, 0, 16'h0020);
    cyc("halt", 1, 1, 1, 1, 1, 0, 1, 16'h0077);
    chk("halt_pc_const", 32'(bus.pc), 32'h20);
    cyc("halt_ign", 1, 1, 0, 0, 0, 1, 0, 16'h0);

    // 6: wrap, stall with branch&jump, reset mid-run
    cyc("rst6", 0, 0, 0, 0, 0, 0, 0, 16'h0);
    cyc("toffff", 1, 1, 1, 1, 0, 0, 0, 16'hFFFF);
    cyc("wrap", 1, 1, 0, 0, 0, 0, 0, 16'h0);
    chk("wrap_pc_const", 32'(bus.pc), 0);
    for (int i = 0; i < 4; i++) cyc("stall", 1, 0, 1, 1, 0, 0, 0, 16'h0ABC);
    cyc("run6", 1, 1, 0, 0, 0, 0, 0, 16'h0);
    cyc("rst_mid", 0, 1, 0, 0, 0, 0, 0, 16'h0);

    // Randomized run; sticky states are cleared by occasional resets
    for (int i = 0; i < 400; i++) begin
      r  = !(($urandom_range(0, 49) == 0) ||
             ((m_halted || m_fault) && $urandom_range(0, 3) == 0));
      s  = ($urandom_range(0, 3) != 0);
      b  = $urandom_range(0, 1) != 0;
      j  = $urandom_range(0, 1) != 0;
      c  = ($urandom_range(0, 4) == 0);
      rt = ($urandom_range(0, 4) == 0);
      h  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cyc("rand", r, s, b, j, c, rt, h, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
